// File: rtl/fp_mul_pkg.sv
// Shared constants and state encoding for the multiplier arbiter and its
// single-precision multiplier.
package fp_mul_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;
  localparam int EXP_BIAS = 127;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/floating_point_mul.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Subnormals flush to zero, zero results are +0, NaN results are a quiet NaN.
module floating_point_mul
  import fp_mul_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] p_o
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic [22:0] frac;
  logic        guard, sticky, rnd;
  logic [23:0] frac_r;
  logic [9:0]  esum;

  assign sign = a_i[SIGN_BIT] ^ b_i[SIGN_BIT];
  assign ea   = a_i[EXP_MSB:EXP_LSB];
  assign eb   = b_i[EXP_MSB:EXP_LSB];
  assign ma   = a_i[MAN_MSB:MAN_LSB];
  assign mb   = b_i[MAN_MSB:MAN_LSB];

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == '0);
  assign b_inf  = (eb == 8'hFF) && (mb == '0);
  assign a_nan  = (ea == 8'hFF) && (ma != '0);
  assign b_nan  = (eb == 8'hFF) && (mb != '0);

  assign prod = 48'({1'b1, ma}) * 48'({1'b1, mb});

  // The 1.x * 1.x product lies in [1,4); bit 47 selects the normalising shift.
  always_comb begin
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + 24'(rnd);
    esum   = 10'(ea) + 10'(eb) + 10'(prod[47]) + 10'(frac_r[23]);
  end

  // A rounding carry leaves frac_r[22:0] all zero, i.e. mantissa 1.0 at exponent+1.
  always_comb begin
    p_o = {sign, 8'(esum - 10'(EXP_BIAS)), frac_r[22:0]};
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      p_o = QNAN;
    end else if (a_inf | b_inf | (esum >= 10'(EXP_BIAS + 255))) begin
      p_o = {sign, 8'hFF, 23'd0};
    end else if (a_zero | b_zero | (esum <= 10'(EXP_BIAS))) begin
      p_o = '0;
    end
  end

endmodule

// File: rtl/fp_mul_rr_arbiter.sv
// Combinational round-robin grant: the first valid requester at or after ptr,
// wrapping modulo NUM_REQ, plus its binary index.
module fp_mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic found;

  // First pass covers [ptr, NUM_REQ); the second covers the wrapped [0, ptr).
  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path can
    // leave one unassigned and infer a latch.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = ID_W'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one floating_point_mul between NUM_REQ requesters: registered operands
// in, registered product out, valid/ready response with the owner's ID.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_product,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q;
  logic [FP_W-1:0]   op_a_q, op_b_q, prod_q;
  logic [FP_W-1:0]   mul_p;
  logic [FP_W-1:0]   a_arr [NUM_REQ];
  logic [FP_W-1:0]   b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              can_accept;
  logic              accept;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*FP_W +: FP_W];
      b_arr[i] = req_b[i*FP_W +: FP_W];
    end
  end

  fp_mul_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  floating_point_mul u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  always_comb begin
    state_d    = state_q;
    can_accept = 1'b0;
    case (state_q)
      IDLE: begin
        can_accept = 1'b1;
        if (grant_any) state_d = MUL;
      end
      MUL:  state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          can_accept = 1'b1;
          state_d    = grant_any ? MUL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked during reset so a requester never sees a handshake that the
  // held-in-reset flops would ignore.
  assign accept    = can_accept & grant_any & rst_n;
  assign req_ready = (can_accept && rst_n) ? grant : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        op_a_q <= a_arr[grant_idx];
        op_b_q <= b_arr[grant_idx];
        id_q   <= grant_idx;
      end
      if (state_q == MUL) prod_q <= mul_p;
    end
  end

  assign resp_valid   = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign resp_id      = id_q;
  assign resp_product = prod_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: a transaction-level occupancy model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fp_mul_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_product;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] s_ready, s_acc;
  logic         s_valid;
  logic [ID_W-1:0] s_id;
  logic [31:0]  s_prod;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference single-precision product for normal or zero operands, from the
  // exact integer product and a remainder-based round-half-to-even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p, q, rem, half;
    int e, sh;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    ma = {41'd0, 1'b1, a[22:0]};
    mb = {41'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    return {a[31] ^ b[31], e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(9) == 0) return 32'h0;
    return {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  // Model: at most one transaction in flight; it is either being computed or
  // being presented. The priority pointer is a plain integer.
  initial begin : compare
    bit m_occ, m_pres, n_occ, n_pres;
    int m_ptr, n_ptr, m_id, n_id, gi, c;
    logic [31:0] m_prod, n_prod;
    bit can;
    logic [31:0] exp_ready;
    m_occ = 0; m_pres = 0; m_ptr = 0; m_id = 0; m_prod = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        check("rst_resp_product", resp_product, 32'h0);
        m_occ = 0; m_pres = 0; m_ptr = 0; m_id = 0;
        continue;
      end
      gi = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (gi < 0 && req_valid[c]) gi = c;
      end
      can = !m_occ || (m_pres && resp_ready);
      exp_ready = (can && gi >= 0) ? (32'd1 << gi) : 32'd0;
      check("req_ready", 32'(req_ready), exp_ready);
      check("resp_valid", 32'(resp_valid), 32'(m_occ && m_pres));
      check("busy", 32'(busy), 32'(m_occ));
      if (m_occ && m_pres) begin
        check("resp_id", 32'(resp_id), 32'(m_id));
        check("resp_product", resp_product, m_prod);
      end
      n_occ = m_occ; n_pres = m_pres; n_ptr = m_ptr; n_id = m_id; n_prod = m_prod;
      if (m_occ && m_pres && resp_ready) n_occ = 0;
      else if (m_occ && !m_pres) n_pres = 1;
      if (can && gi >= 0) begin
        n_occ  = 1;
        n_pres = 0;
        n_id   = gi;
        n_prod = fmul(req_a[gi*32 +: 32], req_b[gi*32 +: 32]);
        n_ptr  = (gi + 1) % N;
      end
      @(posedge clk);
      if (rst_n) begin
        m_occ = n_occ; m_pres = n_pres; m_ptr = n_ptr; m_id = n_id; m_prod = n_prod;
      end else begin
        m_occ = 0; m_pres = 0; m_ptr = 0; m_id = 0;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // One clock: snapshot outputs at the falling edge, return at posedge+1 with
  // accepted requesters dropped unless they keep presenting.
  task automatic cycle(input bit keep = 1'b0);
    @(negedge clk);
    s_ready = req_ready;
    s_acc   = req_ready & req_valid;
    s_valid = resp_valid;
    s_id    = resp_id;
    s_prod  = resp_product;
    @(posedge clk);
    #1;
    if (!keep) req_valid = req_valid & ~s_acc;
  endtask

  task automatic wait_resp(input string nm, input int exp_id, input logic [31:0] exp_p);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_valid) begin
        check({nm, "_id"}, 32'(s_id), 32'(exp_id));
        check({nm, "_product"}, s_prod, exp_p);
        return;
      end
    end
    check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin : stim
    int rid[$];
    int rcyc[$];
    logic [31:0] rprod[$];
    logic [31:0] rr_prod [4];
    rr_prod = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    rst_n      = 1'b0;

    // Round robin, all requesters valid continuously from reset.
    for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, rr_prod[i]);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_direct", 32'(busy), 32'h0);
    check("rst_ready_direct", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    for (int t = 0; t < 16; t++) begin
      cycle(1'b1);
      if (s_valid) begin
        rid.push_back(int'(s_id));
        rprod.push_back(s_prod);
        rcyc.push_back(t);
      end
    end
    check("rr_count_ge6", 32'(rid.size() >= 6), 32'd1);
    for (int j = 0; j < 6 && j < rid.size(); j++) begin
      check($sformatf("rr_id%0d", j), 32'(rid[j]), 32'(j % 4));
      check($sformatf("rr_prod%0d", j), rprod[j], rr_prod[j % 4]);
      if (j > 0) check($sformatf("rr_gap%0d", j), 32'(rcyc[j] - rcyc[j-1]), 32'd2);
    end
    drain();

    // Single request from requester 1.
    set_req(1, 32'h40A80000, 32'h400CCCCD);
    cycle();
    check("single_ready", 32'(s_ready), 32'h2);
    cycle();
    check("single_mul_not_valid", 32'(s_valid), 32'h0);
    cycle();
    check("single_valid", 32'(s_valid), 32'h1);
    check("single_id", 32'(s_id), 32'd1);
    check("single_product", s_prod, 32'h4138CCCD);
    drain();

    // Backpressure with requester 2 waiting.
    set_req(0, 32'hBE99999A, 32'h3F800000);
    cycle();
    check("bp_accept0", 32'(s_acc), 32'h1);
    resp_ready = 1'b0;
    set_req(2, 32'h40000000, 32'h40400000);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_hold_valid", 32'(s_valid), 32'h1);
      check("bp_hold_product", s_prod, 32'hBE99999A);
      check("bp_hold_ready", 32'(s_ready), 32'h0);
    end
    resp_ready = 1'b1;
    cycle();
    check("bp_release_ready", 32'(s_ready), 32'h4);
    check("bp_release_valid", 32'(s_valid), 32'h1);
    wait_resp("bp_second", 2, 32'h40C00000);

    // Zero operand.
    set_req(3, 32'hBE99999A, 32'h00000000);
    wait_resp("zero", 3, 32'h00000000);

    // Negative operands.
    set_req(2, 32'hC0A80000, 32'hC00CCCCD);
    wait_resp("neg", 2, 32'h4138CCCD);
    drain();

    // Reset while the multiplier stage is occupied; ptr is 3 beforehand.
    set_req(1, 32'h3F800000, 32'h40000000);
    cycle();
    check("rstmid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid_resp_valid", 32'(resp_valid), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    set_req(0, 32'h40400000, 32'h40400000);
    set_req(3, 32'h40800000, 32'h40800000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("rstmid_ptr0_wins", 32'(s_ready), 32'h1);
    wait_resp("rstmid_r0", 0, 32'h41100000);
    wait_resp("rstmid_r3", 3, 32'h41800000);
    drain();

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) set_req(i, rand_fp(), rand_fp());
      end
      resp_ready = ($urandom_range(3) != 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
